// File: rtl/rip_axi_slave_mem_if.sv
// AXI4 bundle carrying the channel signals used by the slave memory.
// The slave modport faces the responder, the master modport faces the requester.
interface rip_axi_interface #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    input  ARID, ARADDR, ARLEN, ARVALID, RREADY,
    output AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWVALID, WDATA, WSTRB, WLAST, WVALID, BREADY,
    output ARID, ARADDR, ARLEN, ARVALID, RREADY,
    input  AWREADY, WREADY, BID, BRESP, BVALID, ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface

// File: rtl/rip_axi_slave_mem.sv
// AXI4 slave backed by a dual-port word memory; independent write and read FSMs,
// INCR bursts only, one transaction per channel, every response OKAY.
module rip_axi_slave_mem #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic       clk,
  input  logic       rstn,
  rip_axi_interface.slave S_AXI,
  output logic [1:0] dbg_w_state,
  output logic [1:0] dbg_r_state
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Handshake rule on every channel: a transfer happens on the rising edge where
  // VALID and READY are both high; VALID never waits on READY and holds its payload.
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_FETCH = 2'd1, R_DATA = 2'd2} r_state_e;

  w_state_e              w_state_q, w_state_d;
  logic [IDX_W-1:0]      w_idx_q, w_idx_d;
  logic [ID_WIDTH-1:0]   bid_q, bid_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;

  r_state_e              r_state_q, r_state_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [7:0]            r_len_q, r_len_d;
  logic [7:0]            r_cnt_q, r_cnt_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic                  w_beat;

  assign w_beat = S_AXI.WVALID && wready_q;

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    bid_d     = bid_q;
    unique case (w_state_q)
      W_IDLE: if (S_AXI.AWVALID && awready_q) begin
        bid_d     = S_AXI.AWID;
        w_idx_d   = S_AXI.AWADDR[OFF_W +: IDX_W];
        w_state_d = W_DATA;
      end
      W_DATA: if (w_beat) begin
        w_idx_d = w_idx_q + IDX_W'(1);
        if (S_AXI.WLAST) w_state_d = W_RESP;
      end
      W_RESP: if (S_AXI.BREADY && bvalid_q) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    // Outputs are registered copies of the next-state decode.
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    rid_d     = rid_q;
    unique case (r_state_q)
      R_IDLE: if (S_AXI.ARVALID && arready_q) begin
        rid_d     = S_AXI.ARID;
        r_idx_d   = S_AXI.ARADDR[OFF_W +: IDX_W];
        r_len_d   = S_AXI.ARLEN;
        r_cnt_d   = 8'd0;
        r_state_d = R_FETCH;
      end
      R_FETCH: r_state_d = R_DATA;
      R_DATA: if (S_AXI.RREADY && rvalid_q) begin
        if (rlast_q) begin
          r_state_d = R_IDLE;
        end else begin
          r_idx_d   = r_idx_q + IDX_W'(1);
          r_cnt_d   = r_cnt_q + 8'd1;
          r_state_d = R_FETCH;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rlast_d   = (r_state_d == R_DATA) && (r_cnt_d == r_len_d);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      bid_q     <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      rid_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      bid_q     <= bid_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_cnt_q   <= r_cnt_d;
      rid_q     <= rid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // Storage has no reset; contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (rstn && w_beat) begin
      for (int i = 0; i < NB; i++) begin
        if (S_AXI.WSTRB[i]) mem_q[w_idx_q][i*8 +: 8] <= S_AXI.WDATA[i*8 +: 8];
      end
    end
  end

  // Read-first: a same-edge write to this word lands after the old value is taken.
  always_ff @(posedge clk) begin
    if (!rstn) rdata_q <= '0;
    else if (r_state_q == R_FETCH) rdata_q <= mem_q[r_idx_q];
  end

  assign S_AXI.AWREADY = awready_q;
  assign S_AXI.WREADY  = wready_q;
  assign S_AXI.BID     = bid_q;
  assign S_AXI.BRESP   = 2'b00;
  assign S_AXI.BVALID  = bvalid_q;
  assign S_AXI.ARREADY = arready_q;
  assign S_AXI.RID     = rid_q;
  assign S_AXI.RDATA   = rdata_q;
  assign S_AXI.RRESP   = 2'b00;
  assign S_AXI.RLAST   = rlast_q;
  assign S_AXI.RVALID  = rvalid_q;

  assign dbg_w_state = w_state_q;
  assign dbg_r_state = r_state_q;
endmodule
